alu_muldiv_ctrl: RTL and testbench

//  Iterative 32x32 multiply/divide sequencer. Owns one dedicated alu instance and drives it for 32 cycles per op:

---
 rtl/alu_muldiv_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_alu_muldiv_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_ctrl.sv
// Iterative 32x32 multiply/divide sequencer driving a dedicated alu: shift-add MUL, restoring DIV.
// Signed MULS/DIVS (magnitude + FIX correction state) are built only when MULDIV_SIGNED_EN is defined.
module alu_muldiv_ctrl (
   input  logic        clk,
   input  logic        reset_,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [3:0]  alu_op,
   output logic [31:0] alu_in_0,
   output logic [31:0] alu_in_1,
   input  logic [31:0] alu_out,
   output logic        busy,
   output logic        rsp_valid,
   input  logic        rsp_ack,
   output logic [31:0] rsp_lo,
   output logic [31:0] rsp_hi,
   output logic        rsp_dz
);

   localparam int unsigned DW    = 32;
   localparam int unsigned ITER  = 32;
   localparam int unsigned CNT_W = 5;

   localparam logic [3:0] ALU_OP_ADDU = 4'h0;
   localparam logic [3:0] ALU_OP_SUBU = 4'h1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
`ifdef MULDIV_SIGNED_EN
   localparam logic [1:0] ST_FIX  = 2'd2;
`endif
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]    hi_q, hi_d;
   logic [DW-1:0]    lo_q, lo_d;
   logic [DW-1:0]    opnd_q, opnd_d;
   logic             div_q, div_d;
   logic             dz_q, dz_d;
   logic [DW-1:0]    rsp_lo_d, rsp_hi_d;
   logic             rsp_dz_d, req_ready_d, busy_d, rsp_valid_d;
   logic [3:0]       alu_op_d;
   logic [DW-1:0]    alu_in_0_d, alu_in_1_d;
   logic [DW-1:0]    win_lo;
   logic             mul_carry, div_ok;
   logic [DW-1:0]    a_mag, b_mag;

`ifdef MULDIV_SIGNED_EN
   logic             sgn_q, sgn_d;
   logic             neg_q_q, neg_q_d;
   logic             neg_r_q, neg_r_d;
   logic [2*DW-1:0]  prod_neg;
`else
   logic             unused_op_sign;
   assign unused_op_sign = req_op[1];
`endif

   // Next-state, datapath update and next values of all registered outputs
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      div_d    = div_q;
      dz_d     = dz_q;
      rsp_lo_d = rsp_lo;
      rsp_hi_d = rsp_hi;
      rsp_dz_d = rsp_dz;
      a_mag    = req_a;
      b_mag    = req_b;
`ifdef MULDIV_SIGNED_EN
      sgn_d    = sgn_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
      prod_neg = '0 - {hi_q, lo_q};
      if (req_op[1]) begin
         if (req_a[DW-1]) a_mag = '0 - req_a;
         if (req_b[DW-1]) b_mag = '0 - req_b;
      end
`endif
      // alu_in_0 carries hi_q (MUL) or the low word of the 33-bit remainder window (DIV)
      win_lo    = {hi_q[DW-2:0], lo_q[DW-1]};
      mul_carry = (alu_out < hi_q);
      div_ok    = hi_q[DW-1] | (win_lo >= opnd_q);

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = ST_CALC;
               cnt_d   = '0;
               div_d   = req_op[0];
               dz_d    = req_op[0] & (req_b == '0);
               hi_d    = '0;
               lo_d    = req_op[0] ? a_mag : b_mag;
               opnd_d  = req_op[0] ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
               sgn_d   = req_op[1];
               neg_q_d = req_a[DW-1] ^ req_b[DW-1];
               neg_r_d = req_a[DW-1];
`endif
            end
         end
         ST_CALC: begin
            if (div_q) begin
               hi_d = div_ok ? alu_out : win_lo;
               lo_d = {lo_q[DW-2:0], div_ok};
            end else begin
               hi_d = {mul_carry, alu_out[DW-1:1]};
               lo_d = {alu_out[0], lo_q[DW-1:1]};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITER - 1)) begin
`ifdef MULDIV_SIGNED_EN
               state_d = sgn_q ? ST_FIX : ST_DONE;
`else
               state_d = ST_DONE;
`endif
            end
         end
`ifdef MULDIV_SIGNED_EN
         ST_FIX: begin
            if (div_q) begin
               if (neg_q_q) lo_d = '0 - lo_q;
               if (neg_r_q) hi_d = '0 - hi_q;
            end else if (neg_q_q) begin
               {hi_d, lo_d} = prod_neg;
            end
            state_d = ST_DONE;
         end
`endif
         ST_DONE: begin
            if (rsp_ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (flush) state_d = ST_IDLE;

      if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
         rsp_lo_d = lo_d;
         rsp_hi_d = hi_d;
         rsp_dz_d = dz_d;
      end

      req_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);

      // alu inputs are registered, so they are formed from the next-cycle operands
      alu_op_d   = ALU_OP_ADDU;
      alu_in_0_d = '0;
      alu_in_1_d = '0;
      if (state_d == ST_CALC) begin
         if (div_d) begin
            alu_op_d   = ALU_OP_SUBU;
            alu_in_0_d = {hi_d[DW-2:0], lo_d[DW-1]};
            alu_in_1_d = opnd_d;
         end else begin
            alu_in_0_d = hi_d;
            alu_in_1_d = lo_d[0] ? opnd_d : '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         opnd_q    <= '0;
         div_q     <= 1'b0;
         dz_q      <= 1'b0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_lo    <= '0;
         rsp_hi    <= '0;
         rsp_dz    <= 1'b0;
         alu_op    <= ALU_OP_ADDU;
         alu_in_0  <= '0;
         alu_in_1  <= '0;
`ifdef MULDIV_SIGNED_EN
         sgn_q     <= 1'b0;
         neg_q_q   <= 1'b0;
         neg_r_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         opnd_q    <= opnd_d;
         div_q     <= div_d;
         dz_q      <= dz_d;
         req_ready <= req_ready_d;
         busy      <= busy_d;
         rsp_valid <= rsp_valid_d;
         rsp_lo    <= rsp_lo_d;
         rsp_hi    <= rsp_hi_d;
         rsp_dz    <= rsp_dz_d;
         alu_op    <= alu_op_d;
         alu_in_0  <= alu_in_0_d;
         alu_in_1  <= alu_in_1_d;
`ifdef MULDIV_SIGNED_EN
         sgn_q     <= sgn_d;
         neg_q_q   <= neg_q_d;
         neg_r_q   <= neg_r_d;
`endif
      end
   end

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Bench for alu_muldiv_ctrl: arithmetic reference model plus per-cycle output compare, random and directed ops.
// Expectations follow MULDIV_SIGNED_EN when it is defined for the build.
module tb_alu_muldiv_ctrl;

   localparam logic [3:0] OP_ADDU = 4'h0;
   localparam logic [3:0] OP_SUBU = 4'h1;
`ifdef MULDIV_SIGNED_EN
   localparam bit SGN = 1'b1;
`else
   localparam bit SGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_, flush, req_valid, req_ready, busy, rsp_valid, rsp_ack, rsp_dz;
   logic [1:0]  req_op;
   logic [31:0] req_a, req_b, alu_in_0, alu_in_1, alu_out, rsp_lo, rsp_hi;
   logic [3:0]  alu_op;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // model state: 0 idle, 1 working, 2 result presented
   int          m_phase = 0;
   int          m_left  = 0;
   int          m_lat   = 33;
   bit          m_div   = 1'b0;
   logic [64:0] m_res   = '0;

   always #5 clk = ~clk;

   assign alu_out = (alu_op == OP_SUBU) ? alu_in_0 - alu_in_1 : alu_in_0 + alu_in_1;

   alu_muldiv_ctrl dut (
      .clk(clk), .reset_(reset_), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .alu_op(alu_op), .alu_in_0(alu_in_0), .alu_in_1(alu_in_1), .alu_out(alu_out),
      .busy(busy), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
      .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_dz(rsp_dz)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // {dz, hi, lo} straight from the arithmetic definition
   function automatic logic [64:0] model_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bit          sgn;
      logic [31:0] am, bm, q, r;
      logic [63:0] p;
      sgn = SGN && op[1];
      am  = (sgn && a[31]) ? 32'd0 - a : a;
      bm  = (sgn && b[31]) ? 32'd0 - b : b;
      if (!op[0]) begin
         p = 64'(am) * 64'(bm);
         if (sgn && (a[31] ^ b[31])) p = 64'd0 - p;
         return {1'b0, p};
      end
      if (bm == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = am;
      end else begin
         q = am / bm;
         r = am % bm;
      end
      if (sgn && (a[31] ^ b[31])) q = 32'd0 - q;
      if (sgn && a[31]) r = 32'd0 - r;
      return {b == 32'd0, r, q};
   endfunction

   always @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         m_phase <= 0;
         m_left  <= 0;
      end else if (flush) begin
         m_phase <= 0;
      end else if (m_phase == 0) begin
         if (req_valid) begin
            m_res   <= model_res(req_op, req_a, req_b);
            m_div   <= req_op[0];
            m_lat   <= (SGN && req_op[1]) ? 34 : 33;
            m_left  <= ((SGN && req_op[1]) ? 34 : 33) - 1;
            m_phase <= 1;
         end
      end else if (m_phase == 1) begin
         m_left <= m_left - 1;
         if (m_left == 1) m_phase <= 2;
      end else if (rsp_ack) begin
         m_phase <= 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         if (!reset_) begin
            check("rst_ready", 64'(req_ready), 64'd1);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_valid", 64'(rsp_valid), 64'd0);
            check("rst_dz", 64'(rsp_dz), 64'd0);
            check("rst_lo", 64'(rsp_lo), 64'd0);
            check("rst_hi", 64'(rsp_hi), 64'd0);
            check("rst_alu_op", 64'(alu_op), 64'(OP_ADDU));
            check("rst_alu_in0", 64'(alu_in_0), 64'd0);
            check("rst_alu_in1", 64'(alu_in_1), 64'd0);
         end else begin
            check("ready", 64'(req_ready), 64'(m_phase == 0));
            check("busy", 64'(busy), 64'(m_phase == 1));
            check("rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
            if (m_phase == 1) begin
               if (m_lat == 34 && m_left == 1) check("fix_alu_op", 64'(alu_op), 64'(OP_ADDU));
               else check("calc_alu_op", 64'(alu_op), 64'(m_div ? OP_SUBU : OP_ADDU));
            end else begin
               check("idle_alu_op", 64'(alu_op), 64'(OP_ADDU));
               check("idle_alu_in0", 64'(alu_in_0), 64'd0);
               check("idle_alu_in1", 64'(alu_in_1), 64'd0);
            end
            if (m_phase == 2) begin
               check("rsp_lo", 64'(rsp_lo), 64'(m_res[31:0]));
               check("rsp_hi", 64'(rsp_hi), 64'(m_res[63:32]));
               check("rsp_dz", 64'(rsp_dz), 64'(m_res[64]));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 100) begin
         step();
         n++;
      end
      if (n == 100) check("ready_timeout", 64'(req_ready), 64'd1);
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int ack_wait, input bit chk, input logic [31:0] elo,
                         input logic [31:0] ehi, input logic edz, input int elat, input bit noise);
      int cyc;
      wait_ready();
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      step();
      req_valid = 1'b0;
      cyc = 1;
      while (!rsp_valid && cyc < 100) begin
         req_valid = noise && ($urandom_range(0, 3) == 0);
         req_op = 2'($urandom_range(0, 3)); req_a = $urandom; req_b = $urandom;
         step();
         cyc++;
      end
      check("rsp_timeout", 64'(rsp_valid), 64'd1);
      if (chk) begin
         check("latency", 64'(cyc), 64'(elat));
         check("lit_lo", 64'(rsp_lo), 64'(elo));
         check("lit_hi", 64'(rsp_hi), 64'(ehi));
         check("lit_dz", 64'(rsp_dz), 64'(edz));
      end
      repeat (ack_wait) begin
         req_valid = noise && ($urandom_range(0, 1) == 0);
         step();
      end
      rsp_ack = 1'b1;
      req_valid = noise && ($urandom_range(0, 1) == 0);
      step();
      rsp_ack = 1'b0;
      req_valid = 1'b0;
      if (chk) check("ready_after_ack", 64'(req_ready), 64'd1);
   endtask

   task automatic run_flush(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int fc, input bit chk);
      bit seen = 1'b0;
      wait_ready();
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      step();
      req_valid = 1'b0;
      repeat (fc - 1) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      if (chk) begin
         check("flush_ready", 64'(req_ready), 64'd1);
         check("flush_busy", 64'(busy), 64'd0);
         repeat (40) begin
            step();
            if (rsp_valid) seen = 1'b1;
         end
         check("flush_no_rsp", 64'(seen), 64'd0);
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      reset_ = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 2'd0;
      req_a = 32'd0; req_b = 32'd0; rsp_ack = 1'b0;
      #1 reset_ = 1'b0;
      #1 chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset_ = 1'b1;
      step();

      run_op(2'b00, 32'd7, 32'd6, 0, 1'b1, 32'd42, 32'd0, 1'b0, 33, 1'b0);
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 33, 1'b0);
      run_op(2'b01, 32'd100, 32'd7, 2, 1'b1, 32'd14, 32'd2, 1'b0, 33, 1'b0);
      run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 0, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 1'b0);
      run_op(2'b01, 32'd5, 32'd0, 0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, 33, 1'b0);
`ifdef MULDIV_SIGNED_EN
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 1'b0);
      run_op(2'b10, 32'hFFFF_FFFD, 32'd5, 0, 1'b1, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 34, 1'b0);
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 34, 1'b0);
`else
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 33, 1'b0);
      run_op(2'b10, 32'hFFFF_FFFD, 32'd5, 0, 1'b1, 32'hFFFF_FFF1, 32'd4, 1'b0, 33, 1'b0);
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 33, 1'b0);
`endif

      run_flush(2'b00, 32'd123, 32'd456, 10, 1'b1);

      // flush alongside a request while idle must not start an op
      wait_ready();
      req_valid = 1'b1; req_op = 2'b00; req_a = 32'd3; req_b = 32'd3; flush = 1'b1;
      step();
      req_valid = 1'b0; flush = 1'b0;
      check("flush_req_ready", 64'(req_ready), 64'd1);
      check("flush_req_busy", 64'(busy), 64'd0);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 5) == 0)
            run_flush(2'($urandom_range(0, 3)), pick(), pick(), $urandom_range(1, 34), 1'b0);
         else
            run_op(2'($urandom_range(0, 3)), pick(), pick(), $urandom_range(0, 3),
                   1'b0, 32'd0, 32'd0, 1'b0, 0, 1'b1);
      end

      // asynchronous reset in the middle of CALC
      wait_ready();
      req_valid = 1'b1; req_op = 2'b01; req_a = 32'd1000; req_b = 32'd3;
      step();
      req_valid = 1'b0;
      repeat (14) step();
      #2 reset_ = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_valid", 64'(rsp_valid), 64'd0);
      check("midrst_ready", 64'(req_ready), 64'd1);
      check("midrst_lo", 64'(rsp_lo), 64'd0);
      check("midrst_alu_op", 64'(alu_op), 64'(OP_ADDU));
      step();
      reset_ = 1'b1;
      step();
      run_op(2'b01, 32'd100, 32'd7, 0, 1'b1, 32'd14, 32'd2, 1'b0, 33, 1'b0);

      repeat (3) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
